// File: rtl/inst_fetch_queue_pkg.sv
// Shared types and constants for the instruction-fetch front end.
package inst_fetch_queue_pkg;

  localparam logic [4:0]  EX_ADEL         = 5'h04;
  localparam int unsigned FS_TO_DS_BUS_WD = 70;

  typedef struct packed {
    logic        ex;
    logic [31:0] inst;
    logic [31:0] pc;
  } fq_entry_t;

  localparam int unsigned FQ_ENTRY_WD = $bits(fq_entry_t);

  typedef enum logic {
    FETCH_RUN,
    FETCH_HALT
  } fetch_state_t;

  function automatic logic pc_misaligned(input logic [31:0] pc);
    return pc[1:0] != 2'b00;
  endfunction

endpackage

// File: rtl/inst_fetch_queue_sync_fifo.sv
// Synchronous FIFO with flush; head data is read straight from registered storage.
module sync_fifo #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 4,
  localparam int unsigned AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      count
);

  localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH - 1);
  localparam logic [AW:0]   FULL_CNT = (AW + 1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (p == LAST_IDX) ? '0 : p + AW'(1);
  endfunction

  always_comb begin
    full    = (count == FULL_CNT);
    empty   = (count == '0);
    do_pop  = pop && !empty;
    do_push = push && (!full || do_pop);
    rdata   = mem[rd_ptr];
  end

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= ptr_inc(wr_ptr);
      if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW + 1)'(1);
        2'b01:   count <= count - (AW + 1)'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush && !reset) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/inst_fetch_queue.sv
// Pipelined instruction fetch: sequential PC generation, multiple sram-like reads
// in flight, instruction queue toward decode, and counted discard on redirect.
module inst_fetch_queue
  import inst_fetch_queue_pkg::*;
#(
  parameter int unsigned MAX_OUTSTANDING = 2,
  parameter int unsigned QUEUE_DEPTH     = 4,
  parameter logic [31:0] RESET_PC        = 32'hbfc00000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        inst_sram_req,
  output logic        inst_sram_wr,
  output logic [1:0]  inst_sram_size,
  output logic [31:0] inst_sram_addr,
  output logic [3:0]  inst_sram_wstrb,
  output logic [31:0] inst_sram_wdata,
  input  logic        inst_sram_addrok,
  input  logic        inst_sram_dataok,
  input  logic [31:0] inst_sram_rdata,
  output logic        fs_to_ds_valid,
  input  logic        ds_allowin,
  output logic [31:0] fs_pc,
  output logic [31:0] fs_inst,
  output logic        fs_ex,
  output logic [4:0]  fs_exccode
);

  localparam int unsigned OW  = $clog2(MAX_OUTSTANDING + 1);
  localparam int unsigned PAW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int unsigned QAW = (QUEUE_DEPTH > 1) ? $clog2(QUEUE_DEPTH) : 1;
  localparam int unsigned CW  = QAW + 2;
  localparam logic [OW-1:0] O_MAX = OW'(MAX_OUTSTANDING);
  localparam logic [CW-1:0] Q_CAP = CW'(QUEUE_DEPTH);

  fetch_state_t state, state_next;
  logic [31:0]  fetch_pc, fetch_pc_next;
  logic [OW-1:0] o_cnt, o_next;
  logic [OW-1:0] d_cnt, d_next;

  logic          pend_full, pend_empty, pend_pop;
  logic [PAW:0]  pend_count;
  logic [31:0]   pend_pc;

  fq_entry_t     q_wdata, q_head;
  logic          q_full, q_empty, q_push, q_pop;
  logic [QAW:0]  q_count;

  logic          accept, resp_keep, misalign_enq;
  logic [CW-1:0] credit_used;
  logic [FS_TO_DS_BUS_WD-1:0] fs_to_ds_bus;

  assign inst_sram_wr    = 1'b0;
  assign inst_sram_size  = 2'd2;
  assign inst_sram_wstrb = '0;
  assign inst_sram_wdata = '0;
  assign inst_sram_addr  = fetch_pc;

  // pend_count tracks O-D exactly: kept requests push/pop it, discarded ones never enter.
  always_comb begin
    credit_used   = CW'(pend_count) + CW'(q_count);
    inst_sram_req = !reset && !redirect_valid && (state == FETCH_RUN)
                    && !pc_misaligned(fetch_pc) && (o_cnt < O_MAX)
                    && !pend_full && (credit_used < Q_CAP);
  end

  always_comb begin
    accept       = inst_sram_req && inst_sram_addrok;
    resp_keep    = inst_sram_dataok && (d_cnt == '0) && !redirect_valid;
    pend_pop     = resp_keep && !pend_empty;
    misalign_enq = !redirect_valid && (state == FETCH_RUN)
                   && pc_misaligned(fetch_pc) && !q_full;
    q_push       = resp_keep || misalign_enq;
    q_pop        = !q_empty && ds_allowin && !redirect_valid;

    q_wdata = '{ex: 1'b0, inst: inst_sram_rdata, pc: pend_pc};
    if (!resp_keep && misalign_enq) q_wdata = '{ex: 1'b1, inst: '0, pc: fetch_pc};
  end

  always_comb begin
    o_next        = o_cnt + OW'(accept) - OW'(inst_sram_dataok);
    d_next        = d_cnt;
    fetch_pc_next = fetch_pc;
    if (redirect_valid) begin
      // Everything still unanswered after this cycle belongs to the old stream.
      d_next        = o_next;
      fetch_pc_next = redirect_pc;
    end else begin
      if (inst_sram_dataok && (d_cnt != '0)) d_next = d_cnt - OW'(1);
      if (accept) fetch_pc_next = fetch_pc + 32'd4;
    end
  end

  always_comb begin
    state_next = state;
    if (redirect_valid)    state_next = FETCH_RUN;
    else if (misalign_enq) state_next = FETCH_HALT;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= FETCH_RUN;
      fetch_pc <= RESET_PC;
      o_cnt    <= '0;
      d_cnt    <= '0;
    end else begin
      state    <= state_next;
      fetch_pc <= fetch_pc_next;
      o_cnt    <= o_next;
      d_cnt    <= d_next;
    end
  end

  sync_fifo #(
    .WIDTH (32),
    .DEPTH (MAX_OUTSTANDING)
  ) u_pend_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (accept),
    .pop   (pend_pop),
    .flush (redirect_valid),
    .wdata (fetch_pc),
    .rdata (pend_pc),
    .full  (pend_full),
    .empty (pend_empty),
    .count (pend_count)
  );

  sync_fifo #(
    .WIDTH (FQ_ENTRY_WD),
    .DEPTH (QUEUE_DEPTH)
  ) u_inst_queue (
    .clk   (clk),
    .reset (reset),
    .push  (q_push),
    .pop   (q_pop),
    .flush (redirect_valid),
    .wdata (q_wdata),
    .rdata (q_head),
    .full  (q_full),
    .empty (q_empty),
    .count (q_count)
  );

  always_comb begin
    fs_to_ds_valid = !q_empty;
    fs_to_ds_bus   = '0;
    if (!q_empty)
      fs_to_ds_bus = {q_head.ex, (q_head.ex ? EX_ADEL : 5'd0), q_head.inst, q_head.pc};
  end

  assign {fs_ex, fs_exccode, fs_inst, fs_pc} = fs_to_ds_bus;

endmodule

// File: tb/tb_inst_fetch_queue.sv
// Directed and randomized bench for inst_fetch_queue against an expected-PC-stream model.
module tb_inst_fetch_queue;

  localparam int unsigned MAXO = 2;
  localparam int unsigned QD   = 4;
  localparam logic [31:0] RPC  = 32'hbfc00000;

  logic        clk = 1'b0;
  logic        reset;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        inst_sram_req, inst_sram_wr;
  logic [1:0]  inst_sram_size;
  logic [31:0] inst_sram_addr, inst_sram_wdata, inst_sram_rdata;
  logic [3:0]  inst_sram_wstrb;
  logic        inst_sram_addrok, inst_sram_dataok;
  logic        fs_to_ds_valid, ds_allowin, fs_ex;
  logic [31:0] fs_pc, fs_inst;
  logic [4:0]  fs_exccode;

  always #5 clk = ~clk;

  inst_fetch_queue #(
    .MAX_OUTSTANDING (MAXO),
    .QUEUE_DEPTH     (QD),
    .RESET_PC        (RPC)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .redirect_valid   (redirect_valid),
    .redirect_pc      (redirect_pc),
    .inst_sram_req    (inst_sram_req),
    .inst_sram_wr     (inst_sram_wr),
    .inst_sram_size   (inst_sram_size),
    .inst_sram_addr   (inst_sram_addr),
    .inst_sram_wstrb  (inst_sram_wstrb),
    .inst_sram_wdata  (inst_sram_wdata),
    .inst_sram_addrok (inst_sram_addrok),
    .inst_sram_dataok (inst_sram_dataok),
    .inst_sram_rdata  (inst_sram_rdata),
    .fs_to_ds_valid   (fs_to_ds_valid),
    .ds_allowin       (ds_allowin),
    .fs_pc            (fs_pc),
    .fs_inst          (fs_inst),
    .fs_ex            (fs_ex),
    .fs_exccode       (fs_exccode)
  );

  typedef struct {
    logic [31:0] addr;
    int unsigned ready;
  } rsp_t;

  rsp_t        rsp_q[$];
  int unsigned checks = 0, errors = 0, cyc = 0;
  bit          addr_en, data_en, mdl_done;
  int unsigned max_delay, acc_wait;
  logic [31:0] issue_pc, exp_pc;
  int unsigned delivered, dataoks, accepted, ex_seen;

  function automatic logic [31:0] memf(input logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h0f0f_3c3c;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock cycle: memory reacts to req, model checks outputs, then the edge.
  task automatic step();
    rsp_t head;
    #1;
    inst_sram_addrok = 1'b0;
    inst_sram_dataok = 1'b0;
    inst_sram_rdata  = '0;
    if (inst_sram_req && addr_en && acc_wait == 0) inst_sram_addrok = 1'b1;
    if (data_en && rsp_q.size() > 0 && rsp_q[0].ready <= cyc) begin
      inst_sram_dataok = 1'b1;
      inst_sram_rdata  = memf(rsp_q[0].addr);
    end
    #1;
    if (!reset) begin
      if (issue_pc[1:0] != 2'b00) chk("no_req_misaligned", inst_sram_req, 0);
      if (inst_sram_req) chk("issue_addr", inst_sram_addr, issue_pc);
      if (redirect_valid) begin
        exp_pc   = redirect_pc;
        mdl_done = 1'b0;
      end else if (mdl_done) begin
        chk("idle_after_adel", fs_to_ds_valid, 0);
      end else if (fs_to_ds_valid && ds_allowin) begin
        chk("fs_pc", fs_pc, exp_pc);
        if (exp_pc[1:0] != 2'b00) begin
          chk("adel_ex", fs_ex, 1);
          chk("adel_exccode", fs_exccode, 5'h04);
          chk("adel_inst", fs_inst, 0);
          mdl_done = 1'b1;
          ex_seen++;
        end else begin
          chk("fs_ex", fs_ex, 0);
          chk("fs_exccode", fs_exccode, 0);
          chk("fs_inst", fs_inst, memf(exp_pc));
          exp_pc += 32'd4;
        end
        delivered++;
      end
    end
    if (inst_sram_addrok) begin
      rsp_q.push_back('{inst_sram_addr, cyc + 1 + $urandom_range(0, max_delay)});
      issue_pc += 32'd4;
      accepted++;
      acc_wait = $urandom_range(0, max_delay);
    end else if (inst_sram_req && acc_wait > 0) begin
      acc_wait--;
    end
    if (inst_sram_dataok) begin
      head = rsp_q.pop_front();
      dataoks++;
    end
    if (!reset) chk("outstanding_max", rsp_q.size() <= MAXO, 1);
    if (redirect_valid) issue_pc = redirect_pc;
    @(posedge clk);
    cyc++;
    #1;
  endtask

  task automatic do_redirect(input logic [31:0] pc);
    redirect_valid = 1'b1;
    redirect_pc    = pc;
    step();
    redirect_valid = 1'b0;
  endtask

  task automatic fill_outstanding(input string tag);
    for (int i = 0; i < 10; i++) begin
      if (rsp_q.size() == MAXO) break;
      step();
    end
    chk(tag, rsp_q.size(), MAXO);
  endtask

  initial begin
    int unsigned d0, n0, e0;
    logic [31:0] tgt;
    reset = 1'b1; redirect_valid = 1'b0; redirect_pc = '0; ds_allowin = 1'b1;
    inst_sram_addrok = 1'b0; inst_sram_dataok = 1'b0; inst_sram_rdata = '0;
    addr_en = 1'b1; data_en = 1'b1; max_delay = 0; acc_wait = 0; mdl_done = 1'b0;
    issue_pc = RPC; exp_pc = RPC;
    delivered = 0; dataoks = 0; accepted = 0; ex_seen = 0;

    step(); step();
    chk("rst_req", inst_sram_req, 0);
    chk("rst_valid", fs_to_ds_valid, 0);
    chk("rst_fs_pc", fs_pc, 0);
    chk("rst_fs_inst", fs_inst, 0);
    chk("rst_fs_ex", fs_ex, 0);
    chk("rst_exccode", fs_exccode, 0);
    chk("const_bus", {inst_sram_wr, inst_sram_size, inst_sram_wstrb}, {1'b0, 2'd2, 4'd0});
    chk("const_wdata", inst_sram_wdata, 0);
    reset = 1'b0;
    #1;
    chk("first_req", inst_sram_req, 1);
    chk("first_addr", inst_sram_addr, RPC);

    for (int i = 0; i < 10; i++) step();
    d0 = delivered;
    for (int i = 0; i < 20; i++) step();
    chk("throughput", delivered - d0, 20);

    ds_allowin = 1'b0;
    do_redirect(32'hbfc01000);
    n0 = accepted;
    for (int i = 0; i < 10; i++) step();
    chk("bp_accepted", accepted - n0, QD);
    chk("bp_valid", fs_to_ds_valid, 1);
    chk("bp_head_pc", fs_pc, 32'hbfc01000);
    ds_allowin = 1'b1;
    d0 = delivered;
    for (int i = 0; i < 10; i++) step();
    chk("bp_release", delivered - d0 >= 4, 1);

    data_en = 1'b0;
    fill_outstanding("d2_fill");
    #1;
    chk("o_limit_req", inst_sram_req, 0);
    do_redirect(32'hbfc00380);
    data_en = 1'b1;
    n0 = dataoks;
    for (int i = 0; i < 20; i++) begin
      step();
      if (fs_to_ds_valid) break;
    end
    chk("d2_dataoks", dataoks - n0, 3);
    chk("d2_first_pc", fs_pc, 32'hbfc00380);

    data_en = 1'b0;
    fill_outstanding("d1_fill");
    data_en = 1'b1;
    do_redirect(32'hbfc00500);
    n0 = dataoks;
    for (int i = 0; i < 20; i++) begin
      step();
      if (fs_to_ds_valid) break;
    end
    chk("d1_dataoks", dataoks - n0, 2);
    chk("d1_first_pc", fs_pc, 32'hbfc00500);

    e0 = ex_seen;
    do_redirect(32'hbfc00102);
    for (int i = 0; i < 12; i++) step();
    chk("adel_once", ex_seen - e0, 1);
    chk("adel_idle", fs_to_ds_valid, 0);

    max_delay = 5;
    do_redirect(32'hbfc02000);
    for (int i = 0; i < 3000; i++) begin
      ds_allowin = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 99) < 3) begin
        tgt = RPC + ($urandom_range(0, 1023) << 2);
        if ($urandom_range(0, 7) == 0) tgt = tgt | 32'($urandom_range(1, 3));
        do_redirect(tgt);
      end else begin
        step();
      end
    end

    max_delay = 0;
    acc_wait = 0;
    ds_allowin = 1'b1;
    do_redirect(32'hbfc03000);
    d0 = delivered;
    for (int i = 0; i < 30; i++) step();
    chk("final_progress", delivered - d0 >= 20, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
